// File: rtl/asm_drv_pkg.sv
// Shared types and defaults for the s/x/g pulse driver.
// State encoding and parameter defaults live here.
package asm_drv_pkg;

  localparam int DEF_CNT_W   = 4;
  localparam int DEF_GAP     = 0;
  localparam int DEF_TIMEOUT = 32;
  localparam int DEF_TO_W    = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DRIVE = 3'd2,
    S_GAP   = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/cyc_counter.sv
// Cycle counter with synchronous clear and terminal compare.
// Used to time the GAP and WAIT durations of the driver.
module cyc_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_hit
);

  logic [W-1:0] r_cnt;

  // count up while enabled, restart from zero on clear
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit = (r_cnt == i_limit);

endmodule

// File: rtl/asm_pulse_driver.sv
// Initiator for the s/x/g start-count-acknowledge protocol.
// Strobes s, issues N x pulses, then waits for g with a timeout.
module asm_pulse_driver
  import asm_drv_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int GAP     = DEF_GAP,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W    = DEF_TO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic             g,
  output logic             s,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             early_ack,
  output logic [CNT_W-1:0] pulses_sent
);

  localparam logic [TO_W-1:0] L_GAP =
    TO_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [TO_W-1:0] L_TO =
    TO_W'(TIMEOUT - 1);
  localparam bit HAS_GAP = (GAP > 0);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_ps;
  logic             r_s;
  logic             r_x;
  logic             r_busy;
  logic             r_done;
  logic             r_to;
  logic             r_ea;
  logic             w_last;
  logic             w_gap_hit;
  logic             w_wait_hit;
  logic             w_to_set;
  logic             w_accept;
  logic             w_early;

  assign w_last   = (r_ps == CNT_W'(r_n - 1'b1));
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_early  = g && ((r_state == S_START) ||
                          (r_state == S_DRIVE) ||
                          (r_state == S_GAP));

  cyc_counter #(.W(TO_W)) u_gap_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (r_state != S_GAP),
    .i_en    (1'b1),
    .i_limit (L_GAP),
    .o_hit   (w_gap_hit)
  );

  cyc_counter #(.W(TO_W)) u_wait_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (r_state != S_WAIT),
    .i_en    (1'b1),
    .i_limit (L_TO),
    .o_hit   (w_wait_hit)
  );

  // next-state selection; g beats the timeout limit
  always_comb begin
    w_next   = r_state;
    w_to_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_START;
      end
      S_START: begin
        w_next = S_DRIVE;
      end
      S_DRIVE: begin
        if (w_last) w_next = S_WAIT;
        else if (HAS_GAP) w_next = S_GAP;
      end
      S_GAP: begin
        if (w_gap_hit) w_next = S_DRIVE;
      end
      S_WAIT: begin
        if (g) begin
          w_next = S_DONE;
        end else if (w_wait_hit) begin
          w_next   = S_DONE;
          w_to_set = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // registered strobes decoded from the state being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s    <= 1'b0;
      r_x    <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_s    <= (w_next == S_START);
      r_x    <= (w_next == S_DRIVE);
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
    end
  end

  // transaction bookkeeping: count, pulses, status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_n  <= '0;
      r_ps <= '0;
      r_to <= 1'b0;
      r_ea <= 1'b0;
    end else begin
      if (w_accept) begin
        r_n  <= num_pulses;
        r_ps <= '0;
        r_to <= 1'b0;
        r_ea <= 1'b0;
      end
      if (r_state == S_DRIVE) begin
        r_ps <= r_ps + 1'b1;
      end
      if (w_early) begin
        r_ea <= 1'b1;
      end
      if (w_to_set) begin
        r_to <= 1'b1;
      end
    end
  end

  assign s           = r_s;
  assign x           = r_x;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout     = r_to;
  assign early_ack   = r_ea;
  assign pulses_sent = r_ps;

endmodule

// File: tb/tb_asm_pulse_driver.sv
// Bench for asm_pulse_driver: cycle model plus literal pins.
// Two instances cover GAP=0 and GAP=2.
module tb_asm_pulse_driver;

  localparam int CW  = 4;
  localparam int TMO = 32;

  typedef struct {
    int         d;
    logic [9:0] v;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          st [2];
  logic [CW-1:0] nm [2];
  logic          gi [2];
  logic          so [2];
  logic          xo [2];
  logic          bo [2];
  logic          dn [2];
  logic          to [2];
  logic          ea [2];
  logic [CW-1:0] ps [2];

  exp_t q[$];
  exp_t last_e;

  int ctests = 0;
  int cfail  = 0;
  int ltests = 0;
  int lfail  = 0;
  int xcnt [2] = '{0, 0};
  int dcnt [2] = '{0, 0};
  int dps  [2] = '{0, 0};
  int dto  [2] = '{0, 0};
  int dea  [2] = '{0, 0};

  always #5 clk = ~clk;

  asm_pulse_driver #(
    .CNT_W(CW), .GAP(0), .TIMEOUT(TMO), .TO_W(6)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]),
    .num_pulses(nm[0]), .g(gi[0]), .s(so[0]),
    .x(xo[0]), .busy(bo[0]), .done(dn[0]),
    .timeout(to[0]), .early_ack(ea[0]),
    .pulses_sent(ps[0])
  );

  asm_pulse_driver #(
    .CNT_W(CW), .GAP(2), .TIMEOUT(TMO), .TO_W(6)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]),
    .num_pulses(nm[1]), .g(gi[1]), .s(so[1]),
    .x(xo[1]), .busy(bo[1]), .done(dn[1]),
    .timeout(to[1]), .early_ack(ea[1]),
    .pulses_sent(ps[1])
  );

  function automatic bit anyg(int glo, int ghi,
                              int a, int b);
    return (glo > 0) && (glo <= b) && (ghi >= a)
           && (a <= b);
  endfunction

  function automatic int last_x(int d, int n);
    int gp;
    int p;
    gp = (d == 1) ? 2 : 0;
    p  = (n == 0) ? 16 : n;
    return 2 + (p - 1) * (gp + 1);
  endfunction

  function automatic int done_at(int d, int n,
                                 int glo, int ghi);
    int tl;
    int f;
    tl = last_x(d, n);
    if (!anyg(glo, ghi, tl + 1, tl + TMO))
      return tl + 1 + TMO;
    f = (glo > tl + 1) ? glo : tl + 1;
    return f + 1;
  endfunction

  // expected outputs during cycle t (t=1 is the s cycle)
  function automatic exp_t model(int d, int n, int glo,
                                 int ghi, int t);
    exp_t e;
    int gp;
    int p;
    int tl;
    int td;
    int np;
    int lim;
    bit tmo;
    bit s_, x_, b_, dn_, to_, ea_;
    gp  = (d == 1) ? 2 : 0;
    p   = (n == 0) ? 16 : n;
    tl  = last_x(d, n);
    td  = done_at(d, n, glo, ghi);
    tmo = !anyg(glo, ghi, tl + 1, tl + TMO);
    if (t > td) begin
      s_ = 0; x_ = 0; b_ = 0; dn_ = 0;
      to_ = tmo;
      ea_ = anyg(glo, ghi, 1, tl);
      np  = p;
    end else begin
      s_  = (t == 1);
      x_  = (t >= 2) && (t <= tl) &&
            ((t - 2) % (gp + 1) == 0);
      b_  = 1;
      dn_ = (t == td);
      to_ = (t == td) ? tmo : 1'b0;
      lim = (t - 1 < tl) ? t - 1 : tl;
      ea_ = anyg(glo, ghi, 1, lim);
      np  = (t <= 2) ? 0 : (t - 3) / (gp + 1) + 1;
      if (np > p) np = p;
    end
    e.d = d;
    e.v = {s_, x_, b_, dn_, to_, ea_, 4'(np % 16)};
    return e;
  endfunction

  function automatic exp_t zero_e(int d);
    exp_t e;
    e.d = d;
    e.v = '0;
    return e;
  endfunction

  // per-cycle check of the selected instance
  always @(posedge clk) begin
    exp_t e;
    logic [9:0] a;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      a = {so[e.d], xo[e.d], bo[e.d], dn[e.d],
           to[e.d], ea[e.d], ps[e.d]};
      ctests++;
      if (a !== e.v) begin
        cfail++;
        $display("FAIL outs dut%0d t=%0t got %b exp %b",
                 e.d, $time, a, e.v);
      end
      if (a[8] === 1'b1) xcnt[e.d]++;
      if (a[6] === 1'b1) begin
        dcnt[e.d]++;
        dps[e.d] = int'(a[3:0]);
        dto[e.d] = int'(a[5]);
        dea[e.d] = int'(a[4]);
      end
    end
  end

  task automatic lchk(string nm_, int act, int exp);
    ltests++;
    if (act != exp) begin
      lfail++;
      $display("FAIL %s got %0d exp %0d", nm_, act, exp);
    end
  endtask

  task automatic drive(int d, bit s_, int n, bit g_);
    for (int i = 0; i < 2; i++) begin
      st[i] = (i == d) ? s_ : 1'b0;
      nm[i] = (i == d) ? 4'(n) : 4'd0;
      gi[i] = (i == d) ? g_ : 1'b0;
    end
  endtask

  task automatic run_txn(int d, int n, int glo, int ghi,
                         bit hold, int rst_at);
    int td;
    td = done_at(d, n, glo, ghi);
    for (int j = 0; j <= td; j++) begin
      @(negedge clk);
      if (j == rst_at) begin
        rst_n = 1'b0;
        drive(d, 1'b0, 0, 1'b0);
        q.push_back(zero_e(d));
        @(negedge clk);
        rst_n = 1'b1;
        last_e = zero_e(d);
        q.push_back(last_e);
        return;
      end
      drive(d, (j == 0) || hold,
            (j == 0) ? n : ~n, anyg(glo, ghi, j, j));
      last_e = model(d, n, glo, ghi, j + 1);
      q.push_back(last_e);
    end
  endtask

  task automatic idle_steps(int k);
    for (int j = 0; j < k; j++) begin
      @(negedge clk);
      drive(last_e.d, 1'b0, 0, 1'b0);
      q.push_back(last_e);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    int d0;
    drive(0, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    q.push_back(zero_e(0));
    @(negedge clk);
    q.push_back(zero_e(1));
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back(zero_e(0));

    lchk("model_td_n15", done_at(0, 15, 17, 17), 18);
    lchk("model_td_gap", done_at(1, 3, 0, 0), 41);
    lchk("model_x_gap", int'(model(1, 3, 0, 0, 5).v[8]), 1);
    lchk("model_ps_wrap", int'(model(0, 0, 18, 18, 20).v[3:0]), 0);

    x0 = xcnt[0]; d0 = dcnt[0];
    run_txn(0, 15, 17, 17, 1'b0, -1);
    settle();
    lchk("n15_xcnt", xcnt[0] - x0, 15);
    lchk("n15_done", dcnt[0] - d0, 1);
    lchk("n15_ps", dps[0], 15);
    lchk("n15_to", dto[0], 0);
    lchk("n15_ea", dea[0], 0);

    x0 = xcnt[1]; d0 = dcnt[1];
    run_txn(1, 3, 0, 0, 1'b0, -1);
    idle_steps(2);
    settle();
    lchk("gap_xcnt", xcnt[1] - x0, 3);
    lchk("gap_done", dcnt[1] - d0, 1);
    lchk("gap_to", dto[1], 1);
    lchk("gap_ps", dps[1], 3);

    x0 = xcnt[0]; d0 = dcnt[0];
    run_txn(0, 0, 18, 18, 1'b0, -1);
    settle();
    lchk("n0_xcnt", xcnt[0] - x0, 16);
    lchk("n0_ps", dps[0], 0);
    lchk("n0_to", dto[0], 0);
    lchk("n0_ea", dea[0], 0);

    x0 = xcnt[0];
    run_txn(0, 5, 3, 3, 1'b0, -1);
    settle();
    lchk("early_xcnt", xcnt[0] - x0, 5);
    lchk("early_ea", dea[0], 1);

    x0 = xcnt[0]; d0 = dcnt[0];
    run_txn(0, 10, 0, 0, 1'b0, 8);
    idle_steps(2);
    settle();
    lchk("rst_xcnt", xcnt[0] - x0, 7);
    lchk("rst_nodone", dcnt[0] - d0, 0);
    x0 = xcnt[0];
    run_txn(0, 2, 4, 4, 1'b0, -1);
    settle();
    lchk("post_rst_xcnt", xcnt[0] - x0, 2);

    x0 = xcnt[0]; d0 = dcnt[0];
    run_txn(0, 2, 0, 0, 1'b1, -1);
    run_txn(0, 3, 5, 5, 1'b0, -1);
    idle_steps(3);
    settle();
    lchk("hold_done", dcnt[0] - d0, 2);
    lchk("hold_xcnt", xcnt[0] - x0, 5);

    settle();
    $display("[TB] %0d tests run, %0d failed",
             ctests + ltests, cfail + lfail);
    $finish;
  end

endmodule
